// File: rtl/ex_unit_pkg.sv
// Shared opcode, class and state encodings for the MIPS32 execute stage.
package ex_unit_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_unit_mul_iter.sv
// Iterative 32-step shift-add multiplier; signed operands are reduced to
// magnitudes on entry and the sign is reapplied to the product in DONE.
module mul_iter
  import ex_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        start,
  input  logic        sgn_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] prod_o
);

  mul_state_e  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_mplier;
  logic        r_neg;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= MUL_IDLE;
      r_cnt   <= 6'd0;
    end else if (!hold) begin
      case (r_state)
        MUL_IDLE: if (start) begin
          r_cnt   <= 6'd0;
          r_state <= MUL_BUSY;
        end
        MUL_BUSY: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= MUL_DONE;
        end
        MUL_DONE: r_state <= MUL_IDLE;
        default:  r_state <= MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      if (r_state == MUL_IDLE && start) begin
        r_mcand  <= {32'h0, mag(a_i, sgn_i)};
        r_mplier <= mag(b_i, sgn_i);
        r_acc    <= 64'h0;
        r_neg    <= sgn_i & (a_i[31] ^ b_i[31]);
      end else if (r_state == MUL_BUSY) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

  assign busy_o = (r_state == MUL_BUSY);
  assign done_o = (r_state == MUL_DONE);
  assign prod_o = r_neg ? -r_acc : r_acc;

endmodule

// File: rtl/ex_unit.sv
// MIPS32 execute stage: ALU, HI/LO, EX/MEM register and iterative multiply.
// Optional signed-overflow trap on ADD/ADDI/SUB via macro EX_OVERFLOW_TRAP_EN.
module ex_unit
  import ex_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        stall_i,
  output logic [4:0]  ex_wd_o,
  output logic        ex_wreg_o,
  output logic [31:0] ex_wdata_o,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic        ov_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  logic               w_is_mul, w_busy, w_done, w_ov;
  logic [63:0]        w_prod;
  logic [31:0]        w_data, w_sum, w_diff;
  logic signed [31:0] w_s1, w_s2;
  logic [31:0]        r_hi, r_lo;
  logic [4:0]         r_wd_p1;
  logic               r_wreg_p1, r_ov_p1;
  logic [31:0]        r_wdata_p1;

  assign w_is_mul = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign w_s1     = reg1_i;
  assign w_s2     = reg2_i;
  assign w_sum    = reg1_i + reg2_i;
  assign w_diff   = reg1_i - reg2_i;

  mul_iter u_mul (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall_i),
    .start  (w_is_mul),
    .sgn_i  (aluop_i == EXE_MULT_OP),
    .a_i    (reg1_i),
    .b_i    (reg2_i),
    .busy_o (w_busy),
    .done_o (w_done),
    .prod_o (w_prod)
  );

  // The arrival cycle stalls too, before the FSM has left IDLE.
  assign stallreq_o = (rst != RstEnable) && (w_busy || (w_is_mul && !w_done));

  always_comb begin
    w_data = ZeroWord;
    case (alusel_i)
      EXE_RES_LOGIC: case (aluop_i)
        EXE_AND_OP: w_data = reg1_i & reg2_i;
        EXE_OR_OP:  w_data = reg1_i | reg2_i;
        EXE_XOR_OP: w_data = reg1_i ^ reg2_i;
        EXE_NOR_OP: w_data = ~(reg1_i | reg2_i);
        default:    w_data = ZeroWord;
      endcase
      EXE_RES_SHIFT: case (aluop_i)
        EXE_SLL_OP: w_data = reg2_i << reg1_i[4:0];
        EXE_SRL_OP: w_data = reg2_i >> reg1_i[4:0];
        EXE_SRA_OP: w_data = w_s2 >>> reg1_i[4:0];
        default:    w_data = ZeroWord;
      endcase
      EXE_RES_ARITHMETIC: case (aluop_i)
        EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: w_data = w_sum;
        EXE_SUB_OP, EXE_SUBU_OP:   w_data = w_diff;
        EXE_SLT_OP, EXE_SLTI_OP:   w_data = {31'h0, w_s1 < w_s2};
        EXE_SLTU_OP, EXE_SLTIU_OP: w_data = {31'h0, reg1_i < reg2_i};
        default:                   w_data = ZeroWord;
      endcase
      EXE_RES_MOVE: case (aluop_i)
        EXE_MOVN_OP, EXE_MOVZ_OP: w_data = reg1_i;
        EXE_MFHI_OP:              w_data = r_hi;
        EXE_MFLO_OP:              w_data = r_lo;
        default:                  w_data = ZeroWord;
      endcase
      default: w_data = ZeroWord;
    endcase
  end

`ifdef EX_OVERFLOW_TRAP_EN
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  always_comb begin
    w_ov = 1'b0;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDI_OP: w_ov = add_ovf(reg1_i, reg2_i, w_sum);
      EXE_SUB_OP:              w_ov = sub_ovf(reg1_i, reg2_i, w_diff);
      default:                 w_ov = 1'b0;
    endcase
  end
`else
  assign w_ov = 1'b0;
`endif

  assign ex_wd_o    = (rst == RstEnable) ? 5'd0 : wd_i;
  assign ex_wreg_o  = (rst != RstEnable) && wreg_i && !w_ov && !w_is_mul;
  assign ex_wdata_o = (rst == RstEnable) ? ZeroWord : w_data;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_hi <= ZeroWord;
      r_lo <= ZeroWord;
    end else if (!stall_i) begin
      if (w_done) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (aluop_i == EXE_MTHI_OP) begin
        r_hi <= reg1_i;
      end else if (aluop_i == EXE_MTLO_OP) begin
        r_lo <= reg1_i;
      end
    end
  end

  // EX -> MEM boundary (_p1)
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_wd_p1    <= 5'd0;
      r_wreg_p1  <= 1'b0;
      r_wdata_p1 <= ZeroWord;
      r_ov_p1    <= 1'b0;
    end else if (!stall_i) begin
      if (stallreq_o) begin
        r_wd_p1    <= 5'd0;
        r_wreg_p1  <= 1'b0;
        r_wdata_p1 <= ZeroWord;
        r_ov_p1    <= 1'b0;
      end else begin
        r_wd_p1    <= ex_wd_o;
        r_wreg_p1  <= ex_wreg_o;
        r_wdata_p1 <= ex_wdata_o;
        r_ov_p1    <= w_ov;
      end
    end
  end

  assign mem_wd_o    = r_wd_p1;
  assign mem_wreg_o  = r_wreg_p1;
  assign mem_wdata_o = r_wdata_p1;
  assign ov_o        = r_ov_p1;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

endmodule

// File: doc/ex_unit.md
# ex_unit

Execute stage of the five-stage MIPS32 core. It consumes the decoded bundle produced by `id` and computes the ALU result. It drives the same-cycle EX forwarding bus back to `id`, and it registers the result into the EX/MEM pipeline register, which also serves as the MEM forwarding source. It owns the HI/LO registers and implements MULT/MULTU with an iterative 32-cycle multiplier that stalls the pipeline through `stallreq_o`.

## Interface
Parameters: none. All opcode and width constants come from `defines.v`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high (`RstEnable`).
- `aluop_i` in 8: operation subtype from `id`.
- `alusel_i` in 3: operation class from `id`.
- `reg1_i` in 32: source operand 1 (register value, or immediate/shamt).
- `reg2_i` in 32: source operand 2.
- `wd_i` in 5: destination register index.
- `wreg_i` in 1: destination write enable.
- `stall_i` in 1: downstream stall; freezes all state.
- `ex_wd_o` out 5: combinational destination index, forwarded to `id`.
- `ex_wreg_o` out 1: combinational write enable, forwarded to `id`.
- `ex_wdata_o` out 32: combinational result, forwarded to `id`.
- `mem_wd_o` out 5: EX/MEM register, destination index.
- `mem_wreg_o` out 1: EX/MEM register, write enable.
- `mem_wdata_o` out 32: EX/MEM register, result.
- `ov_o` out 1: registered signed-overflow flag, aligned with the `mem_*` outputs.
- `hi_o` out 32: architectural HI.
- `lo_o` out 32: architectural LO.
- `stallreq_o` out 1: request to stall IF/ID/EX while the multiply is in progress.

## Operation
**Logic** (`EXE_RES_LOGIC`): AND, OR, XOR, NOR of `reg1_i` and `reg2_i`.

**Shift** (`EXE_RES_SHIFT`): the value shifted is `reg2_i`; the amount is `reg1_i[4:0]`.
- SLL: logical left.
- SRL: logical right.
- SRA: arithmetic right.

**Arithmetic** (`EXE_RES_ARITHMETIC`): all results are 32-bit, wrapped mod 2^32.
- ADD, ADDU, ADDI, ADDIU: `reg1_i + reg2_i`.
- SUB, SUBU: `reg1_i - reg2_i`.
- SLT, SLTI: signed compare; result is 1 or 0.
- SLTU, SLTIU: unsigned compare; result is 1 or 0.

**Move** (`EXE_RES_MOVE`):
- MOVN, MOVZ: data is `reg1_i`; `wreg_i` is passed through unchanged, since `id` already resolved the condition.
- MFHI, MFLO: data is the current HI or LO.
- MTHI, MTLO: load `reg1_i` into HI or LO at the clock edge.

**NOP / unknown class**: data is 0.

**Default pass-through**: `ex_wd_o = wd_i` and `ex_wreg_o = wreg_i`, unless overridden by the overflow rule or by multiply.

**MULT/MULTU**: new codes `EXE_MULT_OP` and `EXE_MULTU_OP`. The instruction never writes a GPR; `ex_wreg_o` is forced to 0.

**Multiplier FSM**: states `IDLE`, `BUSY`, `DONE`.
- `IDLE`: on a MULT/MULTU opcode, latch the operands (magnitudes for MULT, plus the result sign), clear the counter, assert `stallreq_o`, and go to `BUSY`.
- `BUSY`: one shift-add step per cycle with a 6-bit counter. After the 32nd step, go to `DONE`.
- `DONE`: `stallreq_o` is 0. Apply the sign correction, write {HI,LO} at the clock edge, and return to `IDLE`.

**Bubbles**: while `stallreq_o=1` and `stall_i=0`, the EX/MEM register loads a bubble: `mem_wd_o=0`, `mem_wreg_o=0`, `mem_wdata_o=0`, `ov_o=0`.

## Timing
- **EX forwarding**: the `ex_*` outputs are combinational, valid in the same cycle as their inputs.
- **EX/MEM register**: the `mem_*` outputs and `ov_o` update one clock after the inputs.
- **Multiply latency**: `stallreq_o` is high for 33 cycles (the arrival cycle plus 32 `BUSY` cycles). `DONE` is cycle 34. HI/LO are visible from cycle 35.
- **Consecutive moves**: an MFHI issued on the cycle after an MTHI reads the new value, because HI/LO are internal registers.
- **`stall_i=1`**: holds the `mem_*` registers, `ov_o`, HI/LO, FSM state and counter. `stallreq_o` still reflects the FSM state. `stall_i` has priority over every update.
- **Reset**: `rst=1` at any edge, including mid-multiply, returns the FSM to `IDLE`. It clears the counter, HI, LO, all `mem_*` outputs and `ov_o` to 0. While `rst=1`, `stallreq_o` and all `ex_*` outputs are 0.
- **Simultaneous MTHI and multiply completion**: cannot occur, because the pipeline is stalled during the multiply.

## Configuration
- **Macro `EX_OVERFLOW_TRAP_EN` defined**: signed overflow on ADD, ADDI or SUB forces `ex_wreg_o=0`, and `ov_o=1` on the following cycle together with the `mem_*` update.
- **Macro not defined**: `ov_o` is tied to 0 and the wrapped result is written normally.

## Structure
- `defines.v` (shared) holds `RstEnable`, `ZeroWord`, all `EXE_*_OP` and `EXE_RES_*` codes, the new `EXE_MULT_OP` and `EXE_MULTU_OP`, and the FSM state encodings.
- Sub-module `mul_iter` contains the iterative shift-add core. Its interface:
  - inputs: start, signed flag, the two operands;
  - outputs: busy, done, 64-bit product.
- `ex_unit` contains the ALU muxing, the HI/LO registers and the EX/MEM register.

## Test plan
- **ADDU with wrap**: `reg1=0xFFFFFFFF`, `reg2=1`, `wd=5`, `wreg=1` → same cycle `ex_wdata_o=0`; next cycle `mem_wd_o=5`, `mem_wreg_o=1`, `mem_wdata_o=0`.
- **ADD overflow**: `0x7FFFFFFF + 1` → with the macro, `ex_wreg_o=0` and then `ov_o=1`; without it, `mem_wdata_o=0x80000000` and `mem_wreg_o=1`.
- **Multiply**: operands `0xFFFFFFFE` and `3` → `stallreq_o` high for exactly 33 cycles with bubbles on `mem_*`.
  - MULT gives HI=`0xFFFFFFFF`, LO=`0xFFFFFFFA`.
  - MULTU gives HI=`0x00000002`, LO=`0xFFFFFFFA`.
- **Shift and compare**: SRA with `reg1=4`, `reg2=0x80000000` → `0xF8000000`. SLTU with `1` vs `0xFFFFFFFF` → 1. SLT with the same operands → 0.
- **HI move**: MTHI `0x12345678`, then MFHI on the next cycle → `ex_wdata_o=0x12345678`.
- **Reset and stall**: `rst` pulsed at `BUSY` cycle 10 → next cycle all outputs 0, `stallreq_o=0`, HI/LO=0. Separately, `stall_i=1` for 3 cycles mid-multiply → `mem_*` held and completion delayed by exactly 3 cycles.
